// File: rtl/sdram_req_queue.sv
// Request queue in front of the sdram_core controller port: an in-order command FIFO,
// a one-command-at-a-time issue FSM, and a credit-limited read response FIFO.
module sdram_req_queue #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int RSP_DEPTH  = 4,
   localparam int BE_WIDTH  = DATA_WIDTH / 8,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [BE_WIDTH-1:0]   req_be,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] ctrl_addr,
   output logic [DATA_WIDTH-1:0] ctrl_write_data,
   output logic [BE_WIDTH-1:0]   ctrl_wr,
   output logic                  ctrl_rd,
   input  logic                  ctrl_rdy,
   input  logic                  ctrl_rvalid,
   input  logic [DATA_WIDTH-1:0] ctrl_read_data,
   output logic [CNT_W-1:0]      cmd_count,
   output logic                  err_unexp
);
   localparam int AW  = $clog2(DEPTH);
   localparam int RAW = $clog2(RSP_DEPTH);
   localparam int RPW = RAW + 1;
   localparam int RIW = (RAW > 0) ? RAW : 1;
   localparam int OFS = $clog2(BE_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << OFS) - 64'd1);
   localparam logic [RPW:0]          RSP_LIMIT = (RPW + 1)'(RSP_DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   function automatic logic [RIW-1:0] rsp_idx(input logic [RPW-1:0] ptr);
      return RIW'(32'(ptr) % RSP_DEPTH);
   endfunction

   logic                  cmd_we_mem    [DEPTH];
   logic [BE_WIDTH-1:0]   cmd_be_mem    [DEPTH];
   logic [ADDR_WIDTH-1:0] cmd_addr_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] cmd_wdata_mem [DEPTH];
   logic [DATA_WIDTH-1:0] rsp_mem       [RSP_DEPTH];

   logic [AW:0]  cmd_wr_ptr, cmd_rd_ptr;
   logic [RPW-1:0] rsp_wr_ptr, rsp_rd_ptr, rsp_count, rd_inflight;
   state_t       state, state_nxt;
   logic         cmd_push, cmd_pop, cmd_empty;
   logic         ctrl_load, ctrl_clear, rd_accept;
   logic         rsp_push, rsp_pop;
   logic         head_we, head_noop, head_issuable, credit_ok;
   logic [BE_WIDTH-1:0]   head_be;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;
   logic [RPW:0] credit_sum;

   assign cmd_count  = CNT_W'(cmd_wr_ptr - cmd_rd_ptr);
   assign cmd_empty  = (cmd_wr_ptr == cmd_rd_ptr);
   assign req_ready  = (cmd_count < CNT_W'(DEPTH));
   assign cmd_push   = req_valid && req_ready;

   assign head_we    = cmd_we_mem[cmd_rd_ptr[AW-1:0]];
   assign head_be    = cmd_be_mem[cmd_rd_ptr[AW-1:0]];
   assign head_addr  = cmd_addr_mem[cmd_rd_ptr[AW-1:0]];
   assign head_wdata = cmd_wdata_mem[cmd_rd_ptr[AW-1:0]];

   // A read being accepted this edge already holds a response slot.
   assign rd_accept     = (state == ISSUE) && ctrl_rdy && ctrl_rd;
   assign credit_sum    = (RPW + 1)'(rd_inflight) + (RPW + 1)'(rsp_count) + (RPW + 1)'(rd_accept);
   assign credit_ok     = (credit_sum < RSP_LIMIT);
   assign head_noop     = head_we && (head_be == '0);
   assign head_issuable = !cmd_empty && (head_we ? !head_noop : credit_ok);

   assign rsp_count = rsp_wr_ptr - rsp_rd_ptr;
   assign rsp_valid = (rsp_count != '0);
   assign rsp_rdata = rsp_mem[rsp_idx(rsp_rd_ptr)];
   assign rsp_push  = ctrl_rvalid && (rd_inflight != '0);
   assign rsp_pop   = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (head_issuable) state_nxt = ISSUE;
         ISSUE:   if (ctrl_rdy && !head_issuable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ctrl_load  = 1'b0;
      ctrl_clear = 1'b0;
      cmd_pop    = 1'b0;
      case (state)
         IDLE: begin
            ctrl_load = head_issuable;
            cmd_pop   = head_issuable || (!cmd_empty && head_noop);
         end
         ISSUE: begin
            if (ctrl_rdy) begin
               ctrl_load  = head_issuable;
               ctrl_clear = !head_issuable;
               cmd_pop    = head_issuable;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_we_mem[cmd_wr_ptr[AW-1:0]]    <= req_we;
         cmd_be_mem[cmd_wr_ptr[AW-1:0]]    <= req_be;
         cmd_addr_mem[cmd_wr_ptr[AW-1:0]]  <= req_addr;
         cmd_wdata_mem[cmd_wr_ptr[AW-1:0]] <= req_wdata;
      end
      if (rsp_push) rsp_mem[rsp_idx(rsp_wr_ptr)] <= ctrl_read_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_wr_ptr  <= '0;
         cmd_rd_ptr  <= '0;
         rsp_wr_ptr  <= '0;
         rsp_rd_ptr  <= '0;
         rd_inflight <= '0;
         err_unexp   <= 1'b0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
         if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
         if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
         if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
         rd_inflight <= rd_inflight + RPW'(rd_accept) - RPW'(rsp_push);
         if (ctrl_rvalid && (rd_inflight == '0)) err_unexp <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_addr       <= '0;
         ctrl_write_data <= '0;
         ctrl_wr         <= '0;
         ctrl_rd         <= 1'b0;
      end else if (ctrl_load) begin
         ctrl_addr       <= head_addr & ADDR_MASK;
         ctrl_write_data <= head_wdata;
         ctrl_wr         <= head_we ? head_be : '0;
         ctrl_rd         <= !head_we;
      end else if (ctrl_clear) begin
         ctrl_wr <= '0;
         ctrl_rd <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue with an sdram_core-like responder and a
// scoreboard of expected ctrl commands and read responses.
module tb_sdram_req_queue;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata, ctrl_addr, ctrl_write_data;
   logic [3:0]  ctrl_wr;
   logic        ctrl_rd;
   logic        ctrl_rdy = 1'b0, ctrl_rvalid = 1'b0;
   logic [31:0] ctrl_read_data = '0;
   logic [2:0]  cmd_count;
   logic        err_unexp;

   sdram_req_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RSP_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ctrl_addr(ctrl_addr), .ctrl_write_data(ctrl_write_data), .ctrl_wr(ctrl_wr),
      .ctrl_rd(ctrl_rd), .ctrl_rdy(ctrl_rdy), .ctrl_rvalid(ctrl_rvalid),
      .ctrl_read_data(ctrl_read_data), .cmd_count(cmd_count), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] data;
   } cmd_t;

   cmd_t        exp_cmd[$];
   logic [31:0] exp_rsp[$];
   logic [31:0] rv_pending[$];
   int          wr_acc_cyc[$];
   logic [31:0] smem [logic [31:0]];
   logic [31:0] rmem [logic [31:0]];
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int rd_acc_cnt = 0, wr_act_cnt = 0, inject_cnt = 0, rdy_mode = 1;
   int base_rd, base_wr;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive the responder for the coming edge, check what that edge will do, advance.
   task automatic cycle();
      cmd_t        c;
      logic [31:0] a, old;
      ctrl_rdy    = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
      ctrl_rvalid = 1'b0;
      if (rv_pending.size() != 0) begin
         ctrl_rvalid    = 1'b1;
         ctrl_read_data = rv_pending.pop_front();
      end else if (inject_cnt > 0) begin
         ctrl_rvalid    = 1'b1;
         ctrl_read_data = 32'hBAD0_0BAD;
         inject_cnt--;
      end
      if (ctrl_wr != 4'h0) wr_act_cnt++;
      if (ctrl_rdy && (ctrl_rd || ctrl_wr != 4'h0)) begin
         if (exp_cmd.size() == 0) check("cmd_unexp", {ctrl_rd, ctrl_wr}, 5'h0);
         else begin
            c = exp_cmd.pop_front();
            check("cmd_rd", ctrl_rd, !c.we);
            check("cmd_wr", ctrl_wr, c.we ? c.be : 4'h0);
            check("cmd_addr", ctrl_addr, c.addr);
            if (c.we) check("cmd_wdata", ctrl_write_data, c.data);
         end
         a = ctrl_addr;
         old = smem.exists(a) ? smem[a] : init_val(a);
         if (ctrl_wr != 4'h0) begin
            smem[a] = merge(old, ctrl_write_data, ctrl_wr);
            wr_acc_cyc.push_back(cyc);
         end
         if (ctrl_rd) begin
            rv_pending.push_back(old);
            rd_acc_cnt++;
         end
      end
      if (rsp_valid && rsp_ready) begin
         if (exp_rsp.size() == 0) check("rsp_unexp", rsp_valid, 1'b0);
         else check("rsp_data", rsp_rdata, exp_rsp.pop_front());
      end
      if (req_valid && req_ready) begin
         a = req_addr & ~32'h3;
         old = rmem.exists(a) ? rmem[a] : init_val(a);
         c.we = req_we; c.be = req_we ? req_be : 4'h0; c.addr = a; c.data = req_wdata;
         if (!req_we) begin
            exp_cmd.push_back(c);
            exp_rsp.push_back(old);
         end else if (req_be != 4'h0) begin
            exp_cmd.push_back(c);
            rmem[a] = merge(old, req_wdata, req_be);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] data);
      logic acc = 1'b0;
      req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = data;
      for (int i = 0; i < 100 && !acc; i++) begin
         acc = req_ready;
         cycle();
      end
      check("push_accepted", acc, 1'b1);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (exp_cmd.size() != 0 || exp_rsp.size() != 0 ||
                                  rv_pending.size() != 0); i++) cycle();
      check("drain_cmd", exp_cmd.size(), 0);
      check("drain_rsp", exp_rsp.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_ctrl_rd", ctrl_rd, 1'b0);
      check("rst_ctrl_wr", ctrl_wr, 4'h0);
      check("rst_ctrl_addr", ctrl_addr, 32'h0);
      check("rst_cmd_count", cmd_count, 3'd0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_err", err_unexp, 1'b0);
      rst_n = 1'b1;
      cycle();
      check("rst_req_ready", req_ready, 1'b1);

      // Write then read back 0x1234, with the write held off by rdy=0 first.
      rdy_mode = 0;
      push(1'b1, 4'hF, 32'h0000_1234, 32'hDEAD_BEEF);
      cycle();
      check("wr_hold_wr", ctrl_wr, 4'hF);
      check("wr_hold_addr", ctrl_addr, 32'h0000_1234);
      cycle();
      check("wr_hold_wr2", ctrl_wr, 4'hF);
      check("wr_hold_data", ctrl_write_data, 32'hDEAD_BEEF);
      rdy_mode = 1;
      rsp_ready = 1'b1;
      push(1'b0, 4'h0, 32'h0000_1234, 32'h0);
      drain();
      cycle(); cycle();
      check("rd_once", rsp_valid, 1'b0);

      // Address masking of the byte offset.
      rdy_mode = 0;
      push(1'b0, 4'h0, 32'h0000_0007, 32'h0);
      cycle();
      check("mask_rd", ctrl_rd, 1'b1);
      check("mask_addr", ctrl_addr, 32'h0000_0004);
      rdy_mode = 1;
      drain();

      // Credit limit: 8 reads with the response side stalled.
      rsp_ready = 1'b0;
      base_rd = rd_acc_cnt;
      for (int i = 0; i < 8; i++) push(1'b0, 4'h0, 32'h100 + 32'(i * 4), 32'h0);
      for (int i = 0; i < 6; i++) cycle();
      check("full_accepts", rd_acc_cnt - base_rd, 4);
      check("full_count", cmd_count, 3'd4);
      check("full_ready", req_ready, 1'b0);
      check("full_rsp_valid", rsp_valid, 1'b1);
      rsp_ready = 1'b1;
      drain();
      check("full_all_accepts", rd_acc_cnt - base_rd, 8);

      // Back-to-back writes with rdy permanently high.
      wr_acc_cyc.delete();
      push(1'b1, 4'hF, 32'h0000_0A00, 32'h1111_0001);
      push(1'b1, 4'h3, 32'h0000_0B00, 32'h2222_0002);
      push(1'b1, 4'hC, 32'h0000_0C00, 32'h3333_0003);
      drain();
      check("b2b_count", wr_acc_cyc.size(), 3);
      if (wr_acc_cyc.size() == 3) begin
         check("b2b_gap1", wr_acc_cyc[1] - wr_acc_cyc[0], 1);
         check("b2b_gap2", wr_acc_cyc[2] - wr_acc_cyc[1], 1);
      end
      push(1'b0, 4'h0, 32'h0000_0B00, 32'h0);
      push(1'b0, 4'h0, 32'h0000_0C00, 32'h0);
      drain();

      // Unexpected rvalid and a zero-byte-enable write.
      check("err_before", err_unexp, 1'b0);
      inject_cnt = 1;
      cycle(); cycle();
      check("err_set", err_unexp, 1'b1);
      check("err_no_rsp", rsp_valid, 1'b0);
      base_wr = wr_act_cnt;
      push(1'b1, 4'h0, 32'h0000_0200, 32'h7777_7777);
      for (int i = 0; i < 4; i++) cycle();
      check("noop_no_wr", wr_act_cnt - base_wr, 0);
      check("noop_popped", cmd_count, 3'd0);

      // Asynchronous reset while a read is presented.
      rdy_mode = 0;
      push(1'b0, 4'h0, 32'h0000_0040, 32'h0);
      cycle();
      check("mid_rd", ctrl_rd, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rd_drop", ctrl_rd, 1'b0);
      check("async_err_clr", err_unexp, 1'b0);
      exp_cmd.delete(); exp_rsp.delete(); rv_pending.delete();
      cycle(); cycle();
      rst_n = 1'b1;
      cycle();
      check("post_count", cmd_count, 3'd0);
      check("post_rsp_valid", rsp_valid, 1'b0);
      check("post_ready", req_ready, 1'b1);

      // Mixed traffic with a randomly stalling core.
      rdy_mode = 2;
      push(1'b1, 4'h5, 32'h0000_0300, 32'hA1B2_C3D4);
      push(1'b0, 4'h0, 32'h0000_0300, 32'h0);
      push(1'b0, 4'h0, 32'h0000_1234, 32'h0);
      push(1'b1, 4'hF, 32'h0000_0304, 32'h0BAD_CAFE);
      push(1'b0, 4'h0, 32'h0000_0304, 32'h0);
      rdy_mode = 1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
